alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the result until taken.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [DATA_SIZE-1:0] REQ0_A,
  input  logic [DATA_SIZE-1:0] REQ0_B,
  input  logic [1:0]           REQ0_ALUK,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [DATA_SIZE-1:0] REQ1_A,
  input  logic [DATA_SIZE-1:0] REQ1_B,
  input  logic [1:0]           REQ1_ALUK,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic                 RSP_ID,
  output logic [DATA_SIZE-1:0] RSP_Y,
  output logic                 RSP_CYO,
  output logic [7:0]           OP_CNT
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e               state_q;
  logic                 pri_q;
  logic                 id_q;
  logic [DATA_SIZE-1:0] a_q, b_q;
  logic [1:0]           aluk_q;
  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [DATA_SIZE-1:0] rsp_y_q;
  logic                 rsp_cyo_q;
  logic [7:0]           op_cnt_q;

  logic                 grant0, grant1;
  logic [DATA_SIZE-1:0] a_d, b_d;
  logic [1:0]           aluk_d;
  logic [DATA_SIZE:0]   sum;
  logic [DATA_SIZE-1:0] alu_y;
  logic                 alu_cyo;

  // Grants are combinational so READY lands in the same cycle as VALID;
  // gating with RST_N keeps READY low throughout reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (RST_N && state_q == IDLE) begin
      if (REQ0_VALID && (!REQ1_VALID || !pri_q)) grant0 = 1'b1;
      else if (REQ1_VALID)                       grant1 = 1'b1;
    end
  end

  always_comb begin
    a_d    = grant1 ? REQ1_A    : REQ0_A;
    b_d    = grant1 ? REQ1_B    : REQ0_B;
    aluk_d = grant1 ? REQ1_ALUK : REQ0_ALUK;
  end

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    alu_y   = '0;
    alu_cyo = 1'b0;
    case (aluk_q)
      2'b00: begin
        alu_y   = sum[DATA_SIZE-1:0];
        alu_cyo = sum[DATA_SIZE];
      end
      2'b01:   alu_y = a_q & b_q;
      2'b10:   alu_y = ~a_q;
      default: alu_y = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      pri_q       <= 1'b0;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      aluk_q      <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_cyo_q   <= 1'b0;
      op_cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q     <= a_d;
            b_q     <= b_d;
            aluk_q  <= aluk_d;
            id_q    <= grant1;
            pri_q   <= ~grant1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Result registers change only here, so they hold the last result through IDLE.
          rsp_y_q     <= alu_y;
          rsp_cyo_q   <= alu_cyo;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            op_cnt_q    <= op_cnt_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ID     = rsp_id_q;
  assign RSP_Y      = rsp_y_q;
  assign RSP_CYO    = rsp_cyo_q;
  assign OP_CNT     = op_cnt_q;

endmodule
